w5300_udp_rx: RTL
=================

W5300_UDP_RX -- requirements
Module: w5300_udp_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100, meaning clock frequency in MHz.
REQ-002 SHALL have parameter RX_BUFFER_ADDR_WIDTH, default 12, meaning external rx buffer word-address width.
REQ-003 SHALL have parameter POLL_WAIT, default 1000, meaning idle cycles between Sn_RX_RSR polls.
REQ-004 SHALL have port clk, input, 1 bit: clock.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port enable, input, 1 bit: start/continue polling socket 0.
REQ-007 SHALL have port src_ip, output, 32 bits: peer IP of last packet.
REQ-008 SHALL have port src_port, output, 16 bits: peer port of last packet.
REQ-009 SHALL have port rx_size, output, 16 bits: payload byte count of last packet.
REQ-010 SHALL have port rx_data, output, 16 bits: payload word.
REQ-011 SHALL have port rx_buffer_addr, output, RX_BUFFER_ADDR_WIDTH bits: buffer write address.
REQ-012 SHALL have port rx_we, output, 1 bit: buffer write strobe.
REQ-013 SHALL have port rx_done, output, 1 bit: one-cycle packet-complete pulse.
REQ-014 SHALL have port rx_overflow, output, 1 bit: last packet truncated.
REQ-015 SHALL have port busy_n, output, 1 bit: high when idle.
REQ-016 SHALL have port op_status, input, 1 bit: intraconnect access-complete pulse.
REQ-017 SHALL have port rd_data, input, 16 bits: read data, valid when op_status=1.
REQ-018 SHALL have port wr_data, output, 16 bits: intraconnect write data.
REQ-019 SHALL have port caddr, output, 12 bits: {valid_n, op (1=rd, 0=wr), addr[9:0]}.

Function
REQ-020 SHALL hold each access with caddr[11]=0, caddr/wr_data stable, until the cycle op_status=1, then advance; between accesses caddr[11]=1.
REQ-021 SHALL implement states IDLE, RSR_H, RSR_L, CHECK, IP_H, IP_L, PORT, SIZE, DATA, CMD_RECV, DONE, WAIT.
REQ-022 IDLE: busy_n=1; go to RSR_H when enable=1; else stay.
REQ-023 RSR_H/RSR_L SHALL read 0x228/0x22A into 32-bit received-size register.
REQ-024 CHECK: size 0 -> WAIT; nonzero -> IP_H.
REQ-025 IP_H, IP_L, PORT, SIZE SHALL each read FIFO 0x230, capturing src_ip[31:16], src_ip[15:0], src_port, rx_size.
REQ-026 DATA SHALL read 0x230 ceil(rx_size/2) times (rx_size 16-bit, count 16-bit, no overflow).
REQ-027 Each DATA read completion SHALL drive rx_data=rd_data, rx_we=1 for that cycle, rx_buffer_addr incrementing from 0.
REQ-028 Words beyond 2**RX_BUFFER_ADDR_WIDTH SHALL still be read but not written (rx_we=0); rx_overflow=1; no address wrap.
REQ-029 rx_size=0: DATA skipped, go straight to CMD_RECV.
REQ-030 CMD_RECV SHALL write 0x0040 to Sn_CR 0x202 (op=0).
REQ-031 DONE SHALL pulse rx_done for one cycle, then go to RSR_H if enable=1, else IDLE.
REQ-032 WAIT SHALL count POLL_WAIT cycles, then RSR_H if enable=1, else IDLE.
REQ-033 enable deasserted mid-packet SHALL NOT abort; packet completes through DONE.
REQ-034 busy_n SHALL be 0 in every state except IDLE.
REQ-035 src_ip, src_port, rx_size, rx_overflow SHALL hold until the next packet's IP_H (rx_overflow cleared there).

Reset
REQ-036 On rst_n=0 SHALL enter IDLE; caddr=12'hC00, wr_data=0, rx_data=0, rx_buffer_addr=0, rx_we=0, rx_done=0, rx_overflow=0, busy_n=0, src_ip=0, src_port=0, rx_size=0, counters 0.
REQ-037 Reset mid-packet SHALL abandon the access immediately; no RECV issued.

Structure
REQ-038 Socket register offsets (0x202, 0x228, 0x22A, 0x230), RECV code 0x40, caddr field constants SHALL live in a shared w5300 package.
REQ-039 POLL_WAIT counter SHALL be a sub-module w5300_poll_timer.

Verification
REQ-040 RSR=0 -> reads 0x228, 0x22A, WAIT POLL_WAIT cycles, repolls; no FIFO reads.
REQ-041 Packet IP C0A8_0102, port 0x1F90, size 5, data 1111/2222/3333 -> 3 rx_we at addr 0,1,2, write 0x0040 to 0x202, rx_done once, src_ip=C0A80102.
REQ-042 RX_BUFFER_ADDR_WIDTH=2, size 12 -> 6 FIFO reads, 4 rx_we, rx_overflow=1, RECV issued.
REQ-043 size 0 header -> 4 FIFO reads, RECV, rx_done, no rx_we.
REQ-044 op_status delayed 7 cycles per access -> caddr stable throughout, same data result.
REQ-045 rst_n low during DATA -> all outputs reset values next cycle, IDLE, no 0x202 write.

Source files
------------

// File: rtl/w5300_pkg.sv
// Shared W5300 definitions: socket 0 register offsets, command codes, the
// intraconnect caddr field layout and the UDP receive FSM state type.
// caddr layout: {valid_n, op (1=read, 0=write), addr[9:0]}.
package w5300_pkg;

    // Socket 0 register word addresses
    localparam logic [9:0] SN_CR       = 10'h202;
    localparam logic [9:0] SN_RX_RSR_H = 10'h228;
    localparam logic [9:0] SN_RX_RSR_L = 10'h22A;
    localparam logic [9:0] SN_RX_FIFO  = 10'h230;

    // Sn_CR command codes
    localparam logic [15:0] SN_CR_RECV = 16'h0040;

    // caddr fields
    localparam logic        OP_RD      = 1'b1;
    localparam logic        OP_WR      = 1'b0;
    localparam logic [11:0] CADDR_IDLE = 12'hC00;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RSR_H,
        ST_RSR_L,
        ST_CHECK,
        ST_IP_H,
        ST_IP_L,
        ST_PORT,
        ST_SIZE,
        ST_DATA,
        ST_CMD_RECV,
        ST_DONE,
        ST_WAIT
    } rx_state_t;

    function automatic logic [11:0] caddr_rd(input logic [9:0] addr);
        return {1'b0, OP_RD, addr};
    endfunction

    function automatic logic [11:0] caddr_wr(input logic [9:0] addr);
        return {1'b0, OP_WR, addr};
    endfunction

endpackage

// File: rtl/w5300_poll_timer.sv
// Idle-interval timer used between Sn_RX_RSR polls.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : hold high while waiting; low clears the count
//   expired    : high during the CYCLES-th consecutive cycle of run
module w5300_poll_timer #(
    parameter int CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic expired
);

    localparam int LAST = (CYCLES > 1) ? CYCLES - 1 : 0;
    localparam int CW   = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CW-1:0] cnt;

    assign expired = run && (cnt == CW'(LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (!run)
            cnt <= '0;
        else if (!expired)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/w5300_udp_rx.sv
// W5300 socket 0 UDP receiver. Polls Sn_RX_RSR, then drains one packet from
// the socket RX FIFO (peer IP, peer port, size, payload words), streams the
// payload into an external buffer, and hands the space back with RECV.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   enable              : keep polling socket 0
//   src_ip/src_port     : peer of the last packet
//   rx_size             : payload byte count of the last packet
//   rx_data/rx_we/
//   rx_buffer_addr      : payload buffer write port
//   rx_done             : one-cycle pulse when a packet is complete
//   rx_overflow         : last packet did not fit in the buffer
//   busy_n              : high while idle
//   op_status/rd_data   : intraconnect completion pulse and read data
//   caddr/wr_data       : intraconnect command and write data
module w5300_udp_rx
    import w5300_pkg::*;
#(
    parameter int CLK_FREQ             = 100,
    parameter int RX_BUFFER_ADDR_WIDTH = 12,
    parameter int POLL_WAIT            = 1000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable,
    output logic [31:0]                     src_ip,
    output logic [15:0]                     src_port,
    output logic [15:0]                     rx_size,
    output logic [15:0]                     rx_data,
    output logic [RX_BUFFER_ADDR_WIDTH-1:0] rx_buffer_addr,
    output logic                            rx_we,
    output logic                            rx_done,
    output logic                            rx_overflow,
    output logic                            busy_n,
    input  logic                            op_status,
    input  logic [15:0]                     rd_data,
    output logic [15:0]                     wr_data,
    output logic [11:0]                     caddr
);

    localparam int AW = RX_BUFFER_ADDR_WIDTH;
    localparam logic [31:0] BUF_DEPTH = 32'(1) << AW;
    // A zero poll interval (or a nonsensical clock setting) degenerates to a
    // single idle cycle between polls.
    localparam int POLL_CYCLES = (CLK_FREQ > 0 && POLL_WAIT > 0) ? POLL_WAIT : 1;

    rx_state_t   state;
    logic [31:0] rsr;
    logic [15:0] word_cnt;
    logic [15:0] word_total;
    logic        poll_expired;

    // Access belonging to the current state; CADDR_IDLE for non-access states.
    logic [11:0] acc_caddr;
    logic [15:0] acc_wdata;
    logic        acc_done;

    always_comb begin
        acc_caddr = CADDR_IDLE;
        acc_wdata = 16'h0000;
        unique case (state)
            ST_RSR_H:    acc_caddr = caddr_rd(SN_RX_RSR_H);
            ST_RSR_L:    acc_caddr = caddr_rd(SN_RX_RSR_L);
            ST_IP_H,
            ST_IP_L,
            ST_PORT,
            ST_SIZE,
            ST_DATA:     acc_caddr = caddr_rd(SN_RX_FIFO);
            ST_CMD_RECV: begin
                acc_caddr = caddr_wr(SN_CR);
                acc_wdata = SN_CR_RECV;
            end
            default:     acc_caddr = CADDR_IDLE;
        endcase
    end

    // Completion only counts while an access is actually presented.
    assign acc_done = !caddr[11] && op_status;

    w5300_poll_timer #(.CYCLES(POLL_CYCLES)) u_poll_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (state == ST_WAIT),
        .expired (poll_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            caddr          <= CADDR_IDLE;
            wr_data        <= '0;
            rx_data        <= '0;
            rx_buffer_addr <= '0;
            rx_we          <= 1'b0;
            rx_done        <= 1'b0;
            rx_overflow    <= 1'b0;
            busy_n         <= 1'b0;
            src_ip         <= '0;
            src_port       <= '0;
            rx_size        <= '0;
            rsr            <= '0;
            word_cnt       <= '0;
            word_total     <= '0;
        end else begin
            rx_we   <= 1'b0;
            rx_done <= 1'b0;

            // Each access state first presents its access (one idle cycle of
            // caddr between accesses), holds it, and drops it on completion.
            if (!acc_caddr[11] && caddr[11]) begin
                caddr   <= acc_caddr;
                wr_data <= acc_wdata;
            end else if (acc_done) begin
                caddr <= CADDR_IDLE;
            end

            unique case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state  <= ST_RSR_H;
                        busy_n <= 1'b0;
                    end else begin
                        busy_n <= 1'b1;
                    end
                end
                ST_RSR_H: if (acc_done) begin
                    rsr[31:16] <= rd_data;
                    state      <= ST_RSR_L;
                end
                ST_RSR_L: if (acc_done) begin
                    rsr[15:0] <= rd_data;
                    state     <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (rsr == 32'd0) begin
                        state <= ST_WAIT;
                    end else begin
                        state       <= ST_IP_H;
                        rx_overflow <= 1'b0;
                        word_cnt    <= '0;
                    end
                end
                ST_IP_H: if (acc_done) begin
                    src_ip[31:16] <= rd_data;
                    state         <= ST_IP_L;
                end
                ST_IP_L: if (acc_done) begin
                    src_ip[15:0] <= rd_data;
                    state        <= ST_PORT;
                end
                ST_PORT: if (acc_done) begin
                    src_port <= rd_data;
                    state    <= ST_SIZE;
                end
                ST_SIZE: if (acc_done) begin
                    rx_size    <= rd_data;
                    // ceil(bytes/2) without a 17-bit intermediate
                    word_total <= {1'b0, rd_data[15:1]} + 16'(rd_data[0]);
                    state      <= (rd_data == 16'd0) ? ST_CMD_RECV : ST_DATA;
                end
                ST_DATA: if (acc_done) begin
                    rx_data <= rd_data;
                    // Words past the buffer end are drained but dropped; the
                    // address stays on the last valid slot.
                    if ({16'd0, word_cnt} < BUF_DEPTH) begin
                        rx_we          <= 1'b1;
                        rx_buffer_addr <= AW'(word_cnt);
                    end else begin
                        rx_overflow <= 1'b1;
                    end
                    word_cnt <= word_cnt + 16'd1;
                    if (word_cnt + 16'd1 == word_total)
                        state <= ST_CMD_RECV;
                end
                ST_CMD_RECV: if (acc_done) begin
                    rx_done <= 1'b1;
                    state   <= ST_DONE;
                end
                ST_DONE: begin
                    if (enable) begin
                        state <= ST_RSR_H;
                    end else begin
                        state  <= ST_IDLE;
                        busy_n <= 1'b1;
                    end
                end
                ST_WAIT: if (poll_expired) begin
                    if (enable) begin
                        state <= ST_RSR_H;
                    end else begin
                        state  <= ST_IDLE;
                        busy_n <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
